mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 11 +
 rtl/rr_arb2.sv | 47 ++++
 rtl/mem_arbiter.sv | 97 +++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the two-port SRAM arbiter
package mem_arb_pkg;

  localparam int NREQ = 2;

  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-requester one-hot arbiter
// MEM_ARB_RR_EN selects round-robin; otherwise fixed priority with requester 0 first.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            accept,
  output logic [NREQ-1:0] grant
);

`ifdef MEM_ARB_RR_EN
  // Index of the most recent winner; reset to 1 so requester 0 wins first.
  logic last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last <= 1'b1;
    end else if (accept) begin
      last <= grant[1];
    end
  end

  always_comb begin
    grant = '0;
    if (req == 2'b11) begin
      grant = last ? 2'b01 : 2'b10;
    end else begin
      grant = req;
    end
  end
`else
  logic unused_inputs;
  assign unused_inputs = ^{clk, rst, accept};

  always_comb begin
    grant = '0;
    if (req[0]) begin
      grant = 2'b01;
    end else if (req[1]) begin
      grant = 2'b10;
    end
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - arbitrates two requesters onto one registered-output SRAM
// Arbitration policy chosen by MEM_ARB_RR_EN (see rr_arb2).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic                    memclk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ-1:0]         req_we,
  input  logic [NREQ-1:0][AW-1:0] req_addr,
  input  logic [NREQ-1:0][DW-1:0] req_wdata,
  output logic [NREQ-1:0]         rsp_valid,
  output logic [DW-1:0]           rsp_rdata,
  output logic                    mem_cs,
  output logic                    mem_wren,
  output logic                    mem_rden,
  output logic [AW-1:0]           mem_waddr,
  output logic [AW-1:0]           mem_raddr,
  output logic [DW-1:0]           mem_din,
  input  logic [DW-1:0]           mem_dout,
  output logic                    busy
);

  state_t          state;
  logic            owner;
  logic [NREQ-1:0] grant;
  logic            accept;
  logic            idx;
  logic            is_idle;

  rr_arb2 u_arb (
    .clk    (memclk),
    .rst    (rst),
    .req    (req_valid),
    .accept (accept),
    .grant  (grant)
  );

  // Gating with rst keeps req_ready low for the whole reset window.
  assign is_idle   = (state == IDLE) && !rst;
  assign req_ready = is_idle ? grant : '0;
  assign accept    = |(req_valid & req_ready);
  assign idx       = req_ready[1];
  assign busy      = (state == RD_WAIT);

  always_comb begin
    mem_cs    = 1'b0;
    mem_wren  = 1'b0;
    mem_rden  = 1'b0;
    mem_waddr = '0;
    mem_raddr = '0;
    mem_din   = '0;
    if (accept) begin
      mem_cs = 1'b1;
      if (req_we[idx]) begin
        mem_wren  = 1'b1;
        mem_waddr = req_addr[idx];
        mem_din   = req_wdata[idx];
      end else begin
        mem_rden  = 1'b1;
        mem_raddr = req_addr[idx];
      end
    end
  end

  // SRAM output is registered, so read data is valid exactly in RD_WAIT.
  always_comb begin
    rsp_valid = '0;
    rsp_rdata = '0;
    if (state == RD_WAIT) begin
      rsp_valid[owner] = 1'b1;
      rsp_rdata        = mem_dout;
    end
  end

  always_ff @(posedge memclk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      owner <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept && !req_we[idx]) begin
            state <= RD_WAIT;
            owner <= idx;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
